// File: rtl/alu_exec.sv
// Accumulator-based ALU: single-cycle logic/arithmetic/compare ops plus
// iterative 8-step shift-add multiply and restoring divide.
module alu_exec (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] aluOp,
    input  logic [7:0] op2,
    output logic [7:0] acc,
    output logic [7:0] ext,
    output logic       carry,
    output logic       busy,
    output logic       done,
    output logic       divByZero,
    output logic       illegalOp
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} stateT;

    localparam logic [3:0] OP_LD  = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_MUL = 4'd6;
    localparam logic [3:0] OP_DIV = 4'd7;
    localparam logic [3:0] OP_GT  = 4'd8;
    localparam logic [3:0] OP_EQ  = 4'd9;
    localparam logic [3:0] OP_LT  = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd11;

    stateT       state;
    logic [2:0]  stepCnt;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] prod;
    logic [7:0]  divisor;
    logic [7:0]  quo;
    logic [7:0]  rem;

    logic [15:0] prodNext;
    logic [8:0]  trial;
    logic        trialFits;
    logic [7:0]  remNext;
    logic [7:0]  quoNext;
    logic [8:0]  addSum;
    logic [8:0]  subDiff;

    // One multiply step adds the shifted multiplicand; one divide step
    // shifts in the next dividend bit and subtracts when the divisor fits.
    assign prodNext  = mplier[0] ? prod + mcand : prod;
    assign trial     = {rem, quo[7]};
    assign trialFits = trial >= {1'b0, divisor};
    assign remNext   = trialFits ? (trial[7:0] - divisor) : trial[7:0];
    assign quoNext   = {quo[6:0], trialFits};
    assign addSum    = {1'b0, acc} + {1'b0, op2};
    assign subDiff   = {1'b0, acc} - {1'b0, op2};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            stepCnt   <= 3'd0;
            acc       <= 8'd0;
            ext       <= 8'd0;
            carry     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
            illegalOp <= 1'b0;
            mcand     <= 16'd0;
            mplier    <= 8'd0;
            prod      <= 16'd0;
            divisor   <= 8'd0;
            quo       <= 8'd0;
            rem       <= 8'd0;
        end else begin
            done      <= 1'b0;
            divByZero <= 1'b0;
            illegalOp <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (aluOp)
                            OP_LD:  begin acc <= op2;       done <= 1'b1; end
                            OP_AND: begin acc <= acc & op2; done <= 1'b1; end
                            OP_OR:  begin acc <= acc | op2; done <= 1'b1; end
                            OP_XOR: begin acc <= acc ^ op2; done <= 1'b1; end
                            OP_ADD: begin
                                {carry, acc} <= addSum;
                                done         <= 1'b1;
                            end
                            OP_SUB: begin
                                {carry, acc} <= subDiff;
                                done         <= 1'b1;
                            end
                            OP_MUL: begin
                                mcand   <= {8'd0, acc};
                                mplier  <= op2;
                                prod    <= 16'd0;
                                stepCnt <= 3'd0;
                                busy    <= 1'b1;
                                state   <= MUL;
                            end
                            OP_DIV: begin
                                if (op2 == 8'd0) begin
                                    acc       <= 8'hFF;
                                    ext       <= acc;
                                    divByZero <= 1'b1;
                                    done      <= 1'b1;
                                end else begin
                                    divisor <= op2;
                                    quo     <= acc;
                                    rem     <= 8'd0;
                                    stepCnt <= 3'd0;
                                    busy    <= 1'b1;
                                    state   <= DIV;
                                end
                            end
                            OP_GT:  begin acc <= {7'd0, acc > op2};  done <= 1'b1; end
                            OP_EQ:  begin acc <= {7'd0, acc == op2}; done <= 1'b1; end
                            OP_LT:  begin acc <= {7'd0, acc < op2};  done <= 1'b1; end
                            OP_NOT: begin acc <= ~acc;               done <= 1'b1; end
                            default: begin
                                illegalOp <= 1'b1;
                                done      <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    prod    <= prodNext;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    stepCnt <= stepCnt + 3'd1;
                    if (stepCnt == 3'd7) begin
                        {ext, acc} <= prodNext;
                        carry      <= |prodNext[15:8];
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                DIV: begin
                    quo     <= quoNext;
                    rem     <= remNext;
                    stepCnt <= stepCnt + 3'd1;
                    if (stepCnt == 3'd7) begin
                        acc   <= quoNext;
                        ext   <= remNext;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: a reference model pushes expected results to a
// scoreboard queue at each start, popped and compared when done pulses.
module tb_alu_exec;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] ext;
        logic       carry;
        logic       dbz;
        logic       ill;
        int         lat;
    } expT;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] aluOp;
    logic [7:0] op2;
    logic [7:0] acc;
    logic [7:0] ext;
    logic       carry;
    logic       busy;
    logic       done;
    logic       divByZero;
    logic       illegalOp;

    expT        sb[$];
    logic [7:0] mAcc;
    logic [7:0] mExt;
    logic       mCarry;
    int         total = 0;
    int         bad   = 0;

    alu_exec dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .aluOp     (aluOp),
        .op2       (op2),
        .acc       (acc),
        .ext       (ext),
        .carry     (carry),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .illegalOp (illegalOp)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: independent arithmetic on the model registers.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] val);
        expT e;
        logic [15:0] p;
        logic [8:0]  s;
        e.dbz = 1'b0;
        e.ill = 1'b0;
        e.lat = 0;
        case (op)
            4'd0: mAcc = val;
            4'd1: mAcc = mAcc & val;
            4'd2: mAcc = mAcc | val;
            4'd3: mAcc = mAcc ^ val;
            4'd4: begin s = mAcc + val; mAcc = s[7:0]; mCarry = s[8]; end
            4'd5: begin mCarry = (mAcc < val); mAcc = mAcc - val; end
            4'd6: begin
                p = mAcc * val;
                mAcc = p[7:0];
                mExt = p[15:8];
                mCarry = (mExt != 8'd0);
                e.lat = 8;
            end
            4'd7: begin
                if (val == 8'd0) begin
                    mExt = mAcc;
                    mAcc = 8'hFF;
                    e.dbz = 1'b1;
                end else begin
                    mExt = mAcc % val;
                    mAcc = mAcc / val;
                    e.lat = 8;
                end
            end
            4'd8:  mAcc = (mAcc > val)  ? 8'd1 : 8'd0;
            4'd9:  mAcc = (mAcc == val) ? 8'd1 : 8'd0;
            4'd10: mAcc = (mAcc < val)  ? 8'd1 : 8'd0;
            4'd11: mAcc = ~mAcc;
            default: e.ill = 1'b1;
        endcase
        e.acc = mAcc;
        e.ext = mExt;
        e.carry = mCarry;
        sb.push_back(e);
        start = 1'b1;
        aluOp = op;
        op2   = val;
        nextCycle();
        start = 1'b0;
    endtask

    // Waits for done, optionally scrambling op2/aluOp and re-asserting start mid-op.
    task automatic checkOutput(input string tag, input bit disturb);
        expT e;
        int cyc = 0;
        int busyCycles = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) busyCycles++;
            if (disturb) begin
                op2   = 8'($urandom);
                aluOp = 4'($urandom_range(0, 11));
                start = (cyc == 3);
            end
            nextCycle();
            cyc++;
        end
        start = 1'b0;
        checkVal({tag, ".doneSeen"}, {15'd0, done}, 16'd1);
        if (sb.size() == 0) begin
            checkVal({tag, ".sbEmpty"}, 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            checkVal({tag, ".acc"}, {8'd0, acc}, {8'd0, e.acc});
            checkVal({tag, ".ext"}, {8'd0, ext}, {8'd0, e.ext});
            checkVal({tag, ".carry"}, {15'd0, carry}, {15'd0, e.carry});
            checkVal({tag, ".divByZero"}, {15'd0, divByZero}, {15'd0, e.dbz});
            checkVal({tag, ".illegalOp"}, {15'd0, illegalOp}, {15'd0, e.ill});
            checkVal({tag, ".latency"}, 16'(cyc), 16'(e.lat));
            checkVal({tag, ".busyCycles"}, 16'(busyCycles), 16'(e.lat));
        end
        nextCycle();
        checkVal({tag, ".pulseEnd"}, {13'd0, done, divByZero, illegalOp}, 16'd0);
    endtask

    initial begin
        int doneSeen;
        reset = 1'b1;
        start = 1'b0;
        aluOp = 4'd0;
        op2   = 8'd0;
        mAcc = 8'd0; mExt = 8'd0; mCarry = 1'b0;
        repeat (3) nextCycle();
        checkVal("reset.state", {acc, ext}, 16'd0);
        checkVal("reset.flags", {11'd0, carry, busy, done, divByZero, illegalOp}, 16'd0);
        reset = 1'b0;
        nextCycle();

        applyStimulus(4'd0, 8'h3C); checkOutput("ld3C", 1'b0);
        applyStimulus(4'd4, 8'hD0); checkOutput("addD0", 1'b0);

        applyStimulus(4'd0, 8'hFF); checkOutput("ldFF", 1'b0);
        applyStimulus(4'd6, 8'hFF); checkOutput("mulFF", 1'b1);

        applyStimulus(4'd0, 8'd200); checkOutput("ld200", 1'b0);
        applyStimulus(4'd7, 8'd7);   checkOutput("div7", 1'b1);

        applyStimulus(4'd0, 8'h55); checkOutput("ld55", 1'b0);
        applyStimulus(4'd7, 8'h00); checkOutput("div0", 1'b0);

        applyStimulus(4'd0,  8'h0F); checkOutput("ld0F", 1'b0);
        applyStimulus(4'd5,  8'h10); checkOutput("subBorrow", 1'b0);
        applyStimulus(4'd5,  8'h0F); checkOutput("subNoBorrow", 1'b0);
        applyStimulus(4'd3,  8'hFF); checkOutput("xor", 1'b0);
        applyStimulus(4'd1,  8'h3C); checkOutput("and", 1'b0);
        applyStimulus(4'd2,  8'h30); checkOutput("or", 1'b0);
        applyStimulus(4'd8,  8'h10); checkOutput("gt", 1'b0);
        applyStimulus(4'd10, 8'h02); checkOutput("lt", 1'b0);
        applyStimulus(4'd9,  8'h01); checkOutput("eq", 1'b0);
        applyStimulus(4'd11, 8'hA5); checkOutput("not", 1'b0);
        applyStimulus(4'd4,  8'h02); checkOutput("addWrap", 1'b0);
        applyStimulus(4'd6,  8'h00); checkOutput("mulZero", 1'b0);
        applyStimulus(4'd0,  8'hC8); checkOutput("ldC8", 1'b0);
        applyStimulus(4'd14, 8'h77); checkOutput("illegalE", 1'b0);

        repeat (3) nextCycle();
        checkVal("idleHold", {acc, ext}, {mAcc, mExt});

        // Abort a multiply partway through; it must leave no trace.
        applyStimulus(4'd0, 8'h03); checkOutput("ld03", 1'b0);
        applyStimulus(4'd6, 8'h04);
        repeat (3) nextCycle();
        reset = 1'b1;
        #1;
        checkVal("abort.state", {acc, ext}, 16'd0);
        checkVal("abort.flags", {11'd0, carry, busy, done, divByZero, illegalOp}, 16'd0);
        sb.delete();
        mAcc = 8'd0; mExt = 8'd0; mCarry = 1'b0;
        nextCycle();
        reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            nextCycle();
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checkVal("abort.noDone", 16'(doneSeen), 16'd0);
        applyStimulus(4'd4, 8'h05); checkOutput("addAfterReset", 1'b0);
        applyStimulus(4'd7, 8'h02); checkOutput("divAfterReset", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
